impulse_mem_arbiter: RTL

//  Shares one port of the impulse-response RAM between two requesters: the impulse recorder
//  (writer) and the convolution engine (reader). Arbitrates per cycle, registers the winning

---
 rtl/impulse_mem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/impulse_mem_arbiter.sv
// Single-port impulse-response RAM arbiter: recorder writes vs. convolution reads.
// Strict writer priority while recording, round-robin otherwise; read data returned with a valid strobe.
module impulse_mem_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic                  audio_clk,
    input  logic                  rst_in,
    input  logic                  record_active,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_grant,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_grant,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [15:0]           rd_stall_cnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_we,
    output logic                  mem_en,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [0:0] WINNER_READ  = 1'b0;
    localparam logic [0:0] WINNER_WRITE = 1'b1;

    logic [0:0]            last_winner_q, last_winner_d;
    logic                  wr_win, rd_win;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  mem_we_q, mem_we_d;
    logic                  mem_en_q, mem_en_d;
    logic [15:0]           stall_q, stall_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [READ_LATENCY:0] rd_tag_q;

    always_comb begin
        wr_win = 1'b0;
        rd_win = 1'b0;
        if (!rst_in) begin
            wr_win = wr_req && (!rd_req || record_active || (last_winner_q == WINNER_READ));
            rd_win = rd_req && !wr_win;
        end
    end

    assign wr_grant = wr_win;
    assign rd_grant = rd_win;

    always_comb begin
        last_winner_d = last_winner_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_we_d      = 1'b0;
        mem_en_d      = 1'b0;
        stall_d       = stall_q;
        rd_data_d     = rd_data_q;

        if (wr_win) begin
            last_winner_d = WINNER_WRITE;
            mem_addr_d    = wr_addr;
            mem_din_d     = wr_data;
            mem_we_d      = 1'b1;
            mem_en_d      = 1'b1;
        end else if (rd_win) begin
            last_winner_d = WINNER_READ;
            mem_addr_d    = rd_addr;
            mem_en_d      = 1'b1;
        end

        if (rd_req && !rd_win && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end

        if (rd_tag_q[READ_LATENCY]) begin
            rd_data_d = mem_dout;
        end
    end

    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            last_winner_q <= WINNER_READ;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            mem_en_q      <= 1'b0;
            stall_q       <= '0;
            rd_data_q     <= '0;
        end else begin
            last_winner_q <= last_winner_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_we_q      <= mem_we_d;
            mem_en_q      <= mem_en_d;
            stall_q       <= stall_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Tag bit k is set k+1 cycles after a read grant; bit 0 lines up with mem_en.
    always_ff @(posedge audio_clk or posedge rst_in) begin
        if (rst_in) begin
            rd_tag_q[0] <= 1'b0;
        end else begin
            rd_tag_q[0] <= rd_win;
        end
    end

    generate
        for (genvar gi = 1; gi <= READ_LATENCY; gi++) begin : g_rd_tag
            always_ff @(posedge audio_clk or posedge rst_in) begin
                if (rst_in) begin
                    rd_tag_q[gi] <= 1'b0;
                end else begin
                    rd_tag_q[gi] <= rd_tag_q[gi-1];
                end
            end
        end
    endgenerate

    // RAM data arrives in the tag's final cycle; pass it through then, hold the captured copy after.
    assign rd_valid     = rd_tag_q[READ_LATENCY];
    assign rd_data      = rd_tag_q[READ_LATENCY] ? mem_dout : rd_data_q;
    assign rd_stall_cnt = stall_q;
    assign mem_addr     = mem_addr_q;
    assign mem_din      = mem_din_q;
    assign mem_we       = mem_we_q;
    assign mem_en       = mem_en_q;

endmodule
